// File: rtl/bfm_ahbl_responder_if.sv
// AHB-Lite bus bundle between an initiator/fabric and the responder BFM.
interface bfm_ahbl_responder_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata, hready,
    input  hrdata, hreadyout, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata, hready,
    output hrdata, hreadyout, hresp
  );
endinterface

// File: rtl/bfm_ahbl_responder.sv
// AHB-Lite responder BFM: word memory behind a fixed wait-state data phase,
// two-cycle ERROR response for illegal sizes, misalignment and an address window.
module bfm_ahbl_responder #(
  parameter int unsigned MEM_AWIDTH  = 10,
  parameter int unsigned WAIT_STATES = 0,
  parameter bit          ERR_EN      = 1'b0,
  parameter logic [31:0] ERR_BASE    = 32'h0000_0F00,
  parameter logic [31:0] ERR_MASK    = 32'h0000_FF00
) (
  input  logic                       hclk,
  input  logic                       hresetn,
  bfm_ahbl_responder_if.slave        bus,
  output logic [15:0]                xfer_count,
  output logic [7:0]                 err_count
);

  localparam int unsigned Depth    = 2 ** MEM_AWIDTH;
  localparam logic [3:0]  WaitLoad = 4'(WAIT_STATES);

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [MEM_AWIDTH+1:0]   addr_q;
  logic                    write_q;
  logic [1:0]              size_q;
  logic [15:0]             xfer_q;
  logic [7:0]              err_q;
  logic [31:0]             mem [Depth];

  logic                    can_accept;
  logic                    accept;
  logic                    size_err;
  logic                    win_err;
  logic                    acc_err;
  logic [3:0]              lane_en;
  logic                    mem_we;
  logic [MEM_AWIDTH-1:0]   mem_idx;
  logic                    hreadyout;
  logic                    hresp;
  logic                    unused_sink;

  // Only the completing/idle data-phase states can take a new address phase.
  assign can_accept = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);
  assign accept     = can_accept && bus.hsel && bus.hready && bus.htrans[1];

  assign size_err = (bus.hsize > 3'd2) ||
                    ((bus.hsize == 3'd1) && bus.haddr[0]) ||
                    ((bus.hsize == 3'd2) && (bus.haddr[1:0] != 2'b00));
  assign win_err  = ERR_EN && ((bus.haddr & ERR_MASK) == ERR_BASE);
  assign acc_err  = size_err || win_err;

  assign mem_idx = addr_q[MEM_AWIDTH+1:2];
  assign mem_we  = (state_q == StData) && write_q;

  // Burst, protection and lock are accepted but carry no meaning here.
  assign unused_sink = ^{bus.hburst, bus.hprot, bus.hmastlock, bus.htrans[0]};

  // State register and wait-state down-counter.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: new acceptances pipeline straight out of IDLE/DATA/ERR2.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StData, StErr2: begin
        state_d = StIdle;
        cnt_d   = '0;
        if (accept) begin
          if (acc_err) begin
            state_d = StErr1;
          end else if (WAIT_STATES == 0) begin
            state_d = StData;
          end else begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end
        end
      end
      StWait: begin
        if (cnt_q <= 4'd1) begin
          state_d = StData;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StErr1:  state_d = StErr2;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    unique case (state_q)
      StWait: hreadyout = 1'b0;
      StErr1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
      end
      StErr2:  hresp = 1'b1;
      default: ;
    endcase
  end

  assign bus.hreadyout = hreadyout;
  assign bus.hresp     = hresp;
  assign bus.hrdata    = ((state_q == StData) && !write_q) ? mem[mem_idx] : 32'h0;

  // Capture the address-phase control for the following data phase.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 2'd0;
    end else if (accept) begin
      addr_q  <= bus.haddr[MEM_AWIDTH+1:0];
      write_q <= bus.hwrite;
      size_q  <= bus.hsize[1:0];
    end
  end

  // Little-endian byte-lane enables from the captured size and address.
  always_comb begin
    lane_en = 4'b0000;
    unique case (size_q)
      2'd0:    lane_en = 4'b0001 << addr_q[1:0];
      2'd1:    lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  // Memory is not reset; a write lands only at the edge that ends DATA.
  always_ff @(posedge hclk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) mem[mem_idx][8*b +: 8] <= bus.hwdata[8*b +: 8];
      end
    end
  end

  // Transfer counter wraps; error counter sticks at all-ones.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      xfer_q <= '0;
      err_q  <= '0;
    end else begin
      if (state_q == StData) xfer_q <= xfer_q + 16'd1;
      if ((state_q == StErr2) && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
    end
  end

  assign xfer_count = xfer_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_bfm_ahbl_responder.sv
// Randomized bench for the AHB-Lite responder BFM with a transaction-level model.
module tb_bfm_ahbl_responder;

  localparam int unsigned MemAw  = 6;
  localparam int unsigned Depth  = 1 << MemAw;
  localparam int unsigned Waits  = 2;
  localparam logic [31:0] ErrBase = 32'h0000_0F00;
  localparam logic [31:0] ErrMask = 32'h0000_FF00;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  logic        hclk;
  logic        hresetn;
  logic [15:0] xfer_count;
  logic [7:0]  err_count;

  bfm_ahbl_responder_if bus();

  // Single-subordinate fabric: HREADY is this responder's own HREADYOUT.
  assign bus.hready = bus.hreadyout;

  bfm_ahbl_responder #(
    .MEM_AWIDTH  (MemAw),
    .WAIT_STATES (Waits),
    .ERR_EN      (1'b1),
    .ERR_BASE    (ErrBase),
    .ERR_MASK    (ErrMask)
  ) dut (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .bus        (bus),
    .xfer_count (xfer_count),
    .err_count  (err_count)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  int          n_checks = 0;
  int          n_errors = 0;
  bit          abort = 1'b0;
  logic [31:0] mem_m [Depth];
  int          xfer_m = 0;
  int          err_m = 0;
  xfer_t       q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % Depth);
  endfunction

  function automatic bit is_acc(input xfer_t t);
    return t.sel && (t.trans == 2'b10 || t.trans == 2'b11);
  endfunction

  function automatic bit is_err(input xfer_t t);
    int off;
    off = int'(t.addr % 4);
    if (t.size > 2) return 1'b1;
    if (t.size == 1 && (off % 2) != 0) return 1'b1;
    if (t.size == 2 && off != 0) return 1'b1;
    return (t.addr & ErrMask) == ErrBase;
  endfunction

  function automatic xfer_t mk(input logic [31:0] a, input logic w, input logic [2:0] s,
                               input logic [31:0] d);
    xfer_t t;
    t.sel = 1'b1; t.trans = 2'b10; t.addr = a; t.write = w; t.size = s; t.wdata = d;
    return t;
  endfunction

  function automatic xfer_t idle_item();
    xfer_t t;
    t = mk(32'h0, 1'b0, 3'd0, 32'h0);
    t.sel = 1'b0; t.trans = 2'b00;
    return t;
  endfunction

  function automatic xfer_t rand_item();
    xfer_t t;
    int r;
    r = $urandom_range(0, 9);
    t.sel   = ($urandom_range(0, 7) != 0);
    t.trans = (r < 1) ? 2'b00 : (r < 2) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
    t.write = 1'($urandom_range(0, 1));
    t.size  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    t.addr  = 32'($urandom_range(0, 255)) * 4;
    if ($urandom_range(0, 9) == 0) t.addr += 32'($urandom_range(0, 3));
    else if (t.size == 0) t.addr += 32'($urandom_range(0, 3));
    else if (t.size == 1) t.addr += 32'($urandom_range(0, 1)) * 2;
    if ($urandom_range(0, 3) == 0) t.addr |= ($urandom() & 32'hFFFF_0000);
    if ($urandom_range(0, 19) == 0) t.addr = (t.addr & 32'hFFFF_00FF) | 32'h0000_0F00;
    t.wdata = $urandom();
    return t;
  endfunction

  task automatic drive_addr(input xfer_t t);
    bus.hsel      = t.sel;
    bus.haddr     = t.addr;
    bus.htrans    = t.trans;
    bus.hwrite    = t.write;
    bus.hsize     = t.size;
    bus.hburst    = 3'($urandom_range(0, 7));
    bus.hprot     = 4'($urandom_range(0, 15));
    bus.hmastlock = 1'b0;
  endtask

  // Checks one finished data phase, then applies its effect to the model.
  task automatic complete(input xfer_t t, input int low, input int bad);
    bit          acc, err;
    int          exp_low, first, nbytes, i;
    logic        exp_resp;
    logic [31:0] exp_rd, w;
    acc = is_acc(t);
    err = acc && is_err(t);
    exp_low  = !acc ? 0 : err ? 1 : int'(Waits);
    exp_resp = err;
    exp_rd   = (acc && !err && !t.write) ? mem_m[widx(t.addr)] : 32'h0;
    check_val("ready_low_cycles", low, exp_low);
    check_val("hresp", bus.hresp, exp_resp);
    check_val("hrdata", bus.hrdata, exp_rd);
    check_val("wait_phase_outputs", bad, 0);
    check_val("xfer_count", xfer_count, 32'(xfer_m));
    check_val("err_count", err_count, 32'(err_m));
    if (err) begin
      if (err_m < 255) err_m++;
    end else if (acc) begin
      xfer_m = (xfer_m + 1) % 65536;
      if (t.write) begin
        nbytes = 1 << t.size;
        first  = (t.size == 2) ? 0 : int'(t.addr % 4);
        w = mem_m[widx(t.addr)];
        for (i = first; i < first + nbytes; i++) w[8*i +: 8] = t.wdata[8*i +: 8];
        mem_m[widx(t.addr)] = w;
      end
    end
  endtask

  // Pipelined initiator: drains q, address phase overlapping the previous data phase.
  task automatic run_queue();
    xfer_t ap, dp;
    bit    ap_v, dp_v, rdy;
    int    low, bad, stall;
    dp_v = 1'b0; low = 0; bad = 0; stall = 0;
    dp = idle_item();
    @(posedge hclk); #1;
    if (q.size() > 0) begin ap = q.pop_front(); ap_v = 1'b1; end
    else begin ap = idle_item(); ap_v = 1'b0; end
    drive_addr(ap);
    while ((ap_v || dp_v) && !abort) begin
      @(negedge hclk);
      rdy = bus.hreadyout;
      if (!rdy) stall++; else stall = 0;
      if (stall > 20) begin
        check_val("stall_timeout", stall, 0);
        abort = 1'b1;
        break;
      end
      if (dp_v) begin
        if (!rdy) begin
          low++;
          if (bus.hresp !== (is_acc(dp) && is_err(dp))) bad++;
          if (bus.hrdata !== 32'h0) bad++;
          bus.hwdata = $urandom();
        end else begin
          bus.hwdata = dp.wdata;
          complete(dp, low, bad);
        end
      end else begin
        check_val("idle_hreadyout", rdy, 1);
        check_val("idle_hresp", bus.hresp, 0);
      end
      @(posedge hclk); #1;
      if (rdy) begin
        dp = ap; dp_v = ap_v; low = 0; bad = 0;
        if (q.size() > 0) begin ap = q.pop_front(); ap_v = 1'b1; end
        else begin ap = idle_item(); ap_v = 1'b0; end
        drive_addr(ap);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    xfer_t t;
    logic [31:0] old;
    for (int i = 0; i < int'(Depth); i++) mem_m[i] = 32'h0;
    hresetn    = 1'b0;
    bus.hwdata = 32'h0;
    drive_addr(idle_item());
    repeat (3) @(negedge hclk);
    check_val("rst_hreadyout", bus.hreadyout, 1);
    check_val("rst_hresp", bus.hresp, 0);
    check_val("rst_hrdata", bus.hrdata, 0);
    check_val("rst_xfer_count", xfer_count, 0);
    check_val("rst_err_count", err_count, 0);
    hresetn = 1'b1;

    // Give every word a known value so later reads never depend on power-up contents.
    for (int i = 0; i < int'(Depth); i++) q.push_back(mk(32'(i * 4), 1'b1, 3'd2, $urandom()));
    run_queue();

    // Word, byte and halfword lane handling, back-to-back.
    q.push_back(mk(32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF));
    q.push_back(mk(32'h10, 1'b0, 3'd2, 32'h0));
    q.push_back(mk(32'h20, 1'b1, 3'd0, 32'h0000_0011));
    q.push_back(mk(32'h21, 1'b1, 3'd0, 32'h0000_2200));
    q.push_back(mk(32'h22, 1'b1, 3'd0, 32'h0033_0000));
    q.push_back(mk(32'h23, 1'b1, 3'd0, 32'h4400_0000));
    q.push_back(mk(32'h20, 1'b0, 3'd2, 32'h0));
    q.push_back(mk(32'h22, 1'b1, 3'd1, 32'hAABB_0000));
    q.push_back(mk(32'h20, 1'b0, 3'd2, 32'h0));
    // Faulting accesses; the window write must leave its aliased word untouched.
    q.push_back(mk(32'h06, 1'b0, 3'd2, 32'h0));
    q.push_back(mk(32'h0F04, 1'b1, 3'd2, 32'h1234_5678));
    q.push_back(mk(32'h30, 1'b1, 3'd3, 32'hFFFF_FFFF));
    q.push_back(mk(32'h04, 1'b0, 3'd2, 32'h0));
    q.push_back(mk(32'h30, 1'b0, 3'd2, 32'h0));
    // Non-transfers: BUSY/IDLE selected, NONSEQ unselected.
    t = mk(32'h40, 1'b1, 3'd2, 32'h5555_5555); t.trans = 2'b01; q.push_back(t);
    t.trans = 2'b00; q.push_back(t);
    t.trans = 2'b10; t.sel = 1'b0; q.push_back(t);
    q.push_back(mk(32'h40, 1'b0, 3'd2, 32'h0));
    run_queue();

    // Drive the error counter into saturation.
    for (int i = 0; i < 260; i++) q.push_back(mk(32'(i * 4), 1'b0, 3'd3, 32'h0));
    run_queue();

    for (int i = 0; i < 300; i++) q.push_back(rand_item());
    run_queue();

    // Reset in the middle of a write's wait states discards the write.
    if (!abort) begin
      old = mem_m[widx(32'h48)];
      @(posedge hclk); #1;
      drive_addr(mk(32'h48, 1'b1, 3'd2, 32'h0));
      bus.hwdata = ~old;
      @(posedge hclk); #1;
      drive_addr(idle_item());
      @(negedge hclk);
      check_val("pre_rst_wait_hreadyout", bus.hreadyout, 0);
      #2 hresetn = 1'b0;
      #1;
      check_val("midrst_hreadyout", bus.hreadyout, 1);
      check_val("midrst_hresp", bus.hresp, 0);
      check_val("midrst_hrdata", bus.hrdata, 0);
      check_val("midrst_xfer_count", xfer_count, 0);
      check_val("midrst_err_count", err_count, 0);
      xfer_m = 0;
      err_m  = 0;
      @(negedge hclk);
      hresetn = 1'b1;
      q.push_back(mk(32'h48, 1'b0, 3'd2, 32'h0));
      q.push_back(mk(32'h20, 1'b0, 3'd2, 32'h0));
      run_queue();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
